// File: rtl/stack_burst_ctrl.sv
// Burst save/restore sequencer between the register file and the CPU hardware stack; optional STACK_BURST_HWM_EN adds a depth high-water mark.
// Latency: push/pop of N words finishes with done at accept+N+2; rejected or empty requests finish at accept+1.
// Backpressure: req_ready only in IDLE; stall freezes issue/retire, and a skid register holds in-flight data.
`timescale 1ns/1ps
module stack_burst_ctrl #(
   parameter int DEPTH   = 1024,
   parameter int DEPTH_W = 10,
   parameter int REG_W   = 4,
   parameter int CNT_W   = 4
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_req_valid,
   output logic               o_req_ready,
   input  logic               i_req_op,
   input  logic [REG_W-1:0]   i_req_first,
   input  logic [CNT_W-1:0]   i_req_count,
   input  logic               i_stall,
   output logic [REG_W-1:0]   o_rf_raddr,
   input  logic [31:0]        i_rf_rdata,
   output logic               o_rf_we,
   output logic [REG_W-1:0]   o_rf_waddr,
   output logic [31:0]        o_rf_wdata,
   output logic [31:0]        o_stk_d,
   output logic               o_stk_push,
   output logic               o_stk_pop,
   input  logic [31:0]        i_stk_q,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err_overflow,
   output logic               o_err_underflow,
`ifdef STACK_BURST_HWM_EN
   input  logic               i_hwm_clr,
   output logic [DEPTH_W:0]   o_hwm,
`endif
   output logic [DEPTH_W:0]   o_depth
);

   localparam int SUM_W = DEPTH_W + 2;
   localparam logic [DEPTH_W:0] ONE_D = 1;

   typedef enum logic [2:0] {S_IDLE, S_PUSH, S_POP, S_DRAIN, S_FIN} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_op;
   logic [CNT_W-1:0]  r_left;
   logic [REG_W-1:0]  r_addr;
   logic [REG_W-1:0]  r_wa;
   logic              r_pend;
   logic              r_sk_vld;
   logic [31:0]       r_sk_dat;
   logic              r_ovf;
   logic              r_unf;
   logic [DEPTH_W:0]  r_depth;

   logic              w_accept;
   logic [SUM_W-1:0]  w_sum;
   logic              w_ovf;
   logic              w_unf;
   logic              w_empty;
   logic              w_issue;
   logic              w_retire;
   logic [31:0]       w_xfer;

   assign w_accept = i_req_valid & (r_state == S_IDLE);
   assign w_sum    = SUM_W'(r_depth) + SUM_W'(i_req_count);
   assign w_ovf    = ~i_req_op & (w_sum > SUM_W'(DEPTH));
   assign w_unf    = i_req_op & (SUM_W'(i_req_count) > SUM_W'(r_depth));
   assign w_empty  = (i_req_count == '0);

   // one word issued per unstalled PUSH/POP cycle; the previous word retires in the same unstalled cycle
   assign w_issue  = ~i_stall & ((r_state == S_PUSH) | (r_state == S_POP));
   assign w_retire = ~i_stall & r_pend;

   // data for the retiring word: skid copy if a stall interrupted it, else the live read port
   assign w_xfer   = r_sk_vld ? r_sk_dat : (r_op ? i_stk_q : i_rf_rdata);

   assign o_req_ready     = (r_state == S_IDLE);
   assign o_busy          = (r_state != S_IDLE);
   assign o_done          = (r_state == S_FIN);
   assign o_err_overflow  = (r_state == S_FIN) & r_ovf;
   assign o_err_underflow = (r_state == S_FIN) & r_unf;
   assign o_rf_raddr      = r_addr;
   assign o_rf_waddr      = r_wa;
   assign o_rf_wdata      = w_xfer;
   assign o_stk_d         = w_xfer;
   assign o_stk_push      = w_retire & ~r_op;
   assign o_stk_pop       = w_issue & r_op;
   assign o_rf_we         = w_retire & r_op;
   assign o_depth         = r_depth;

   // state register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // next-state: rejected or empty requests go straight to FIN
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_ovf | w_unf | w_empty) w_next = S_FIN;
               else if (i_req_op)           w_next = S_POP;
               else                         w_next = S_PUSH;
            end
         end
         S_PUSH, S_POP: if (w_issue && (r_left == CNT_W'(1))) w_next = S_DRAIN;
         S_DRAIN:       if (w_retire) w_next = S_FIN;
         S_FIN:         w_next = S_IDLE;
         default:       w_next = S_IDLE;
      endcase
   end

   // burst bookkeeping: address walk (up for push, down for pop), remaining count, pending word, skid
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_op     <= 1'b0;
         r_left   <= '0;
         r_addr   <= '0;
         r_wa     <= '0;
         r_pend   <= 1'b0;
         r_sk_vld <= 1'b0;
         r_sk_dat <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op   <= i_req_op;
            r_left <= i_req_count;
            r_addr <= i_req_op ? (i_req_first + REG_W'(i_req_count) - REG_W'(1)) : i_req_first;
            r_ovf  <= w_ovf;
            r_unf  <= w_unf;
         end else if (w_issue) begin
            r_left <= r_left - CNT_W'(1);
            r_addr <= r_op ? (r_addr - REG_W'(1)) : (r_addr + REG_W'(1));
            r_wa   <= r_addr;
         end
         r_pend <= w_issue | (r_pend & i_stall);
         if (w_retire) begin
            r_sk_vld <= 1'b0;
         end else if (r_pend & i_stall & ~r_sk_vld) begin
            r_sk_vld <= 1'b1;
            r_sk_dat <= r_op ? i_stk_q : i_rf_rdata;
         end
      end
   end

   // stack occupancy follows the strobes; push and pop never coincide
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)        r_depth <= '0;
      else if (o_stk_push) r_depth <= r_depth + ONE_D;
      else if (o_stk_pop)  r_depth <= r_depth - ONE_D;
   end

`ifdef STACK_BURST_HWM_EN
   logic [DEPTH_W:0] r_hwm;
   assign o_hwm = r_hwm;

   // high-water mark lags depth by one cycle; clear rebases it to the current depth
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)              r_hwm <= '0;
      else if (i_hwm_clr)        r_hwm <= r_depth;
      else if (r_depth > r_hwm)  r_hwm <= r_depth;
   end
`endif

endmodule

// File: tb/tb_stack_burst_ctrl.sv
// Directed bench for stack_burst_ctrl with register-file and stack models.
// Latency: checks strobe/done cycle offsets relative to the accept cycle.
// Backpressure: exercises stall mid-burst and reset mid-burst.
`timescale 1ns/1ps
module tb_stack_burst_ctrl;
   localparam int DEPTH = 1024, DEPTH_W = 10, REG_W = 4, CNT_W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_valid = 1'b0, req_op = 1'b0, stall = 1'b0;
   logic [REG_W-1:0] req_first = '0;
   logic [CNT_W-1:0] req_count = '0;
   logic req_ready, rf_we, stk_push, stk_pop, busy, done, err_ovf, err_unf;
   logic [REG_W-1:0] rf_raddr, rf_waddr;
   logic [31:0] rf_rdata, rf_wdata, stk_d, stk_q;
   logic [DEPTH_W:0] depth;
`ifdef STACK_BURST_HWM_EN
   logic hwm_clr = 1'b0;
   logic [DEPTH_W:0] hwm;
`endif

   stack_burst_ctrl dut (
      .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_op(req_op), .i_req_first(req_first), .i_req_count(req_count), .i_stall(stall),
      .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr),
      .o_rf_wdata(rf_wdata), .o_stk_d(stk_d), .o_stk_push(stk_push), .o_stk_pop(stk_pop),
      .i_stk_q(stk_q), .o_busy(busy), .o_done(done), .o_err_overflow(err_ovf),
      .o_err_underflow(err_unf),
`ifdef STACK_BURST_HWM_EN
      .i_hwm_clr(hwm_clr), .o_hwm(hwm),
`endif
      .o_depth(depth)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // register file: 1-cycle read latency; rf_load 1 = 0x100+n pattern, 2 = scrub to 0xDEAD
   logic [31:0] regs [16];
   logic [1:0]  rf_load = 2'd0;
   always @(posedge clk) begin
      rf_rdata <= regs[rf_raddr];
      if (rf_load == 2'd1) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'h100 + 32'(i);
      end else if (rf_load == 2'd2) begin
         for (int i = 0; i < 16; i++) regs[i] <= 32'hDEAD;
      end else if (rf_we) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

   // hardware stack model, cleared by the same reset
   logic [31:0] smem [DEPTH];
   logic [10:0] sp;
   logic [10:0] sp_m1;
   assign sp_m1 = sp - 11'd1;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp <= '0;
         stk_q <= '0;
      end else if (stk_push) begin
         smem[sp[9:0]] <= stk_d;
         sp <= sp + 11'd1;
      end else if (stk_pop) begin
         stk_q <= smem[sp_m1[9:0]];
         sp <= sp_m1;
      end
   end

   typedef struct {
      int          c;
      logic [31:0] d;
      logic [3:0]  a;
      logic        ov;
      logic        un;
   } ev_t;
   ev_t push_q[$], pop_q[$], we_q[$], done_q[$];

   // event recorder, sampling 2ns after the falling edge
   always @(negedge clk) begin
      #2;
      if (stk_push) push_q.push_back('{cyc, stk_d, 4'd0, 1'b0, 1'b0});
      if (stk_pop)  pop_q.push_back('{cyc, 32'd0, 4'd0, 1'b0, 1'b0});
      if (rf_we)    we_q.push_back('{cyc, rf_wdata, rf_waddr, 1'b0, 1'b0});
      if (done)     done_q.push_back('{cyc, 32'd0, 4'd0, err_ovf, err_unf});
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_q();
      push_q.delete(); pop_q.delete(); we_q.delete(); done_q.delete();
   endtask

   // present one request in the next cycle; returns the accept cycle, leaves us inside A+1
   task automatic do_req(input logic op, input logic [3:0] first, input logic [3:0] cnt, output int a);
      @(negedge clk);
      clr_q();
      req_op = op; req_first = first; req_count = cnt; req_valid = 1'b1;
      a = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      for (int i = 0; i < lim && done_q.size() == 0; i++) begin
         @(negedge clk);
         #3;
      end
      if (done_q.size() == 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic load_rf(input logic [1:0] mode);
      @(negedge clk); rf_load = mode;
      @(negedge clk); rf_load = 2'd0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a;
      int d;
      int n;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 64'(req_ready), 64'd1);
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_strb",  64'({stk_push, stk_pop, rf_we, err_ovf, err_unf}), 64'd0);
      chk("rst_addr",  64'({rf_raddr, rf_waddr}), 64'd0);
      chk("rst_depth", 64'(depth), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      load_rf(2'd1);

      // push r1..r4
      do_req(1'b0, 4'd1, 4'd4, a);
      wait_done(40);
      chk("p4_npush", 64'(push_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("p4_cyc%0d", i),  64'(push_q[i].c - a), 64'(i + 2));
         chk($sformatf("p4_dat%0d", i),  64'(push_q[i].d), 64'(32'h101 + 32'(i)));
      end
      chk("p4_done", 64'(done_q[0].c - a), 64'd6);
      chk("p4_err",  64'({done_q[0].ov, done_q[0].un}), 64'd0);
      chk("p4_depth", 64'(depth), 64'd4);

      // scrub, then pop the same range back in descending order
      load_rf(2'd2);
      do_req(1'b1, 4'd1, 4'd4, a);
      wait_done(40);
      chk("o4_nwe", 64'(we_q.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("o4_cyc%0d", i),  64'(we_q[i].c - a), 64'(i + 2));
         chk($sformatf("o4_adr%0d", i),  64'(we_q[i].a), 64'(4 - i));
         chk($sformatf("o4_dat%0d", i),  64'(we_q[i].d), 64'(32'h104 - 32'(i)));
      end
      chk("o4_npop", 64'(pop_q.size()), 64'd4);
      chk("o4_done", 64'(done_q[0].c - a), 64'd6);
      chk("o4_depth", 64'(depth), 64'd0);
      chk("o4_r2", 64'(regs[2]), 64'h102);

      // underflow: depth 1, pop 2; then pop 1 exactly empties; count 0 is a no-op
      load_rf(2'd1);
      do_req(1'b0, 4'd5, 4'd1, a);
      wait_done(40);
      chk("u_depth1", 64'(depth), 64'd1);
      do_req(1'b1, 4'd0, 4'd2, a);
      wait_done(40);
      chk("u_done", 64'(done_q[0].c - a), 64'd1);
      chk("u_err",  64'({done_q[0].ov, done_q[0].un}), 64'b01);
      chk("u_nstb", 64'(pop_q.size() + we_q.size()), 64'd0);
      chk("u_depth", 64'(depth), 64'd1);
      do_req(1'b1, 4'd7, 4'd1, a);
      wait_done(40);
      chk("u1_done", 64'(done_q[0].c - a), 64'd3);
      chk("u1_err",  64'({done_q[0].ov, done_q[0].un}), 64'b00);
      chk("u1_we",   64'({we_q[0].a, we_q[0].d}), {32'd0, 4'd7, 32'h105} >> 0);
      chk("u1_depth", 64'(depth), 64'd0);
      do_req(1'b0, 4'd0, 4'd0, a);
      wait_done(40);
      chk("z_done", 64'(done_q[0].c - a), 64'd1);
      chk("z_err",  64'({done_q[0].ov, done_q[0].un}), 64'b00);
      chk("z_nstb", 64'(push_q.size() + pop_q.size()), 64'd0);

      // wrapping push 14,15,0 with a 2-cycle stall
      do_req(1'b0, 4'd14, 4'd3, a);
      #1 chk("w_raddr1", 64'(rf_raddr), 64'd14);
      @(negedge clk); stall = 1'b1;
      #1 chk("w_raddr2", 64'(rf_raddr), 64'd15);
      chk("w_stallstb", 64'(stk_push), 64'd0);
      @(negedge clk);
      @(negedge clk); stall = 1'b0;
      wait_done(40);
      chk("w_npush", 64'(push_q.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("w_cyc%0d", i), 64'(push_q[i].c - a), 64'(i + 4));
      end
      chk("w_dat0", 64'(push_q[0].d), 64'h10E);
      chk("w_dat1", 64'(push_q[1].d), 64'h10F);
      chk("w_dat2", 64'(push_q[2].d), 64'h100);
      chk("w_done", 64'(done_q[0].c - a), 64'd7);
      chk("w_depth", 64'(depth), 64'd3);

      // fill to 1022, then overflow/boundary checks
      d = 3;
      while (d < 1022) begin
         n = (1022 - d > 15) ? 15 : (1022 - d);
         do_req(1'b0, 4'd0, 4'(n), a);
         wait_done(60);
         d += n;
      end
      chk("f_depth", 64'(depth), 64'd1022);
      do_req(1'b0, 4'd0, 4'd3, a);
      wait_done(40);
      chk("ov_done", 64'(done_q[0].c - a), 64'd1);
      chk("ov_err",  64'({done_q[0].ov, done_q[0].un}), 64'b10);
      chk("ov_npush", 64'(push_q.size()), 64'd0);
      chk("ov_depth", 64'(depth), 64'd1022);
      do_req(1'b0, 4'd0, 4'd2, a);
      wait_done(40);
      chk("full_err", 64'({done_q[0].ov, done_q[0].un}), 64'b00);
      chk("full_depth", 64'(depth), 64'd1024);
      do_req(1'b0, 4'd0, 4'd1, a);
      wait_done(40);
      chk("ov1_err", 64'({done_q[0].ov, done_q[0].un}), 64'b10);
      chk("ov1_depth", 64'(depth), 64'd1024);

      // reset in the middle of a pop of 8, after three pops
      do_req(1'b1, 4'd0, 4'd8, a);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rb_npop", 64'(pop_q.size()), 64'd3);
      rst_n = 1'b0;
      #1;
      chk("rb_strb",  64'({stk_pop, rf_we, stk_push}), 64'd0);
      chk("rb_ready", 64'(req_ready), 64'd1);
      chk("rb_depth", 64'(depth), 64'd0);
      chk("rb_busy",  64'(busy), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      clr_q();
      repeat (4) @(negedge clk);
      #3;
      chk("rb_quiet", 64'(push_q.size() + pop_q.size() + we_q.size() + done_q.size()), 64'd0);

`ifdef STACK_BURST_HWM_EN
      do_req(1'b0, 4'd0, 4'd5, a);
      wait_done(40);
      do_req(1'b1, 4'd0, 4'd3, a);
      wait_done(40);
      do_req(1'b0, 4'd0, 4'd1, a);
      wait_done(40);
      @(negedge clk);
      chk("hwm_peak", 64'(hwm), 64'd5);
      chk("hwm_depth", 64'(depth), 64'd3);
      hwm_clr = 1'b1;
      @(negedge clk); hwm_clr = 1'b0;
      #1 chk("hwm_clr", 64'(hwm), 64'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
